// File: rtl/program_loader.sv
// Streams a byte sequence into program RAM over the shared bus,
// holding the CPU at an instruction boundary while it writes.
module program_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_req,
   input  logic              cpu_at_t0,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              nLma,
   output logic              nLmd,
   output logic              nLr,
   output logic              cpu_hold,
   output logic              pc_clr,
   output logic              prog_active,
   output logic [ADDR_W:0]   byte_count,
   output logic              trunc
);

   typedef enum logic [2:0] {
      IDLE, SYNC, READY, ADDR, DATA, WRITE, DONE
   } state_t;

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

   state_t              state, nxt;
   logic [ADDR_W-1:0]   addr_ptr;
   logic [DATA_W-1:0]   hold_data;
   logic                hold_last;
   logic                last_slot;

   assign last_slot = (byte_count == FULL - ONE);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  if (prog_req) nxt = SYNC;
         SYNC:  if (!prog_req) nxt = IDLE;
                else if (cpu_at_t0) nxt = READY;
         READY: if (ld_valid) nxt = ADDR;
                else if (!prog_req) nxt = DONE;
         ADDR:  nxt = DATA;
         DATA:  nxt = WRITE;
         WRITE: nxt = (hold_last || last_slot) ? DONE : READY;
         DONE:  if (!prog_req) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         addr_ptr    <= '0;
         hold_data   <= '0;
         hold_last   <= 1'b0;
         byte_count  <= '0;
         trunc       <= 1'b0;
         ld_ready    <= 1'b0;
         bus_out     <= '0;
         bus_oe      <= 1'b0;
         nLma        <= 1'b1;
         nLmd        <= 1'b1;
         nLr         <= 1'b1;
         cpu_hold    <= 1'b0;
         pc_clr      <= 1'b0;
         prog_active <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && prog_req) begin
            addr_ptr   <= '0;
            byte_count <= '0;
            trunc      <= 1'b0;
         end
         if (state == READY && ld_valid) begin
            hold_data <= ld_data;
            hold_last <= ld_last;
         end
         if (state == WRITE) begin
            addr_ptr <= addr_ptr + ADDR_W'(1);
            if (byte_count != FULL)
               byte_count <= byte_count + ONE;
            if (last_slot && !hold_last)
               trunc <= 1'b1;
         end
         ld_ready    <= (nxt == READY);
         bus_oe      <= (nxt == ADDR) || (nxt == DATA);
         nLma        <= (nxt != ADDR);
         nLmd        <= (nxt != DATA);
         nLr         <= (nxt != WRITE);
         cpu_hold    <= (nxt != IDLE) && (nxt != SYNC);
         prog_active <= (nxt != IDLE);
         pc_clr      <= (nxt == DONE) && (state != DONE);
         case (nxt)
            ADDR:    bus_out <= DATA_W'(addr_ptr);
            DATA:    bus_out <= hold_data;
            default: bus_out <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: spec-level model checked every cycle,
// plus a RAM/MAR environment and directed literal checks.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       prog_req = 1'b0;
   logic       cpu_at_t0 = 1'b0;
   logic       ld_valid = 1'b0;
   logic [7:0] ld_data = 8'h00;
   logic       ld_last = 1'b0;
   logic       ld_ready;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic       nLma;
   logic       nLmd;
   logic       nLr;
   logic       cpu_hold;
   logic       pc_clr;
   logic       prog_active;
   logic [4:0] byte_count;
   logic       trunc;

   program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .prog_req(prog_req),
      .cpu_at_t0(cpu_at_t0), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .bus_out(bus_out),
      .bus_oe(bus_oe), .nLma(nLma), .nLmd(nLmd),
      .nLr(nLr), .cpu_hold(cpu_hold), .pc_clr(pc_clr),
      .prog_active(prog_active),
      .byte_count(byte_count), .trunc(trunc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_pc = 0;
   int acc_q[$];

   // CPU-side input/MAR register and program RAM
   logic [3:0] mar;
   logic [7:0] mdr;
   logic [7:0] ram [16];

   always @(posedge clk) begin
      if (!nLma) mar <= bus_out[3:0];
      if (!nLmd) mdr <= bus_out;
      if (!nLr) ram[mar] <= mdr;
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  name, act, exp);
      end
   endtask

   typedef enum {M_IDLE, M_SYNC, M_LOAD, M_DONE} mmode_t;
   mmode_t     m_mode;
   int         m_age;
   int         m_cnt;
   bit         m_trunc;
   bit         m_first;
   bit         m_last;
   logic [3:0] m_ptr;
   logic [7:0] m_data;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            m_mode = M_IDLE; m_age = 0; m_cnt = 0;
            m_trunc = 0; m_first = 0; m_last = 0;
            m_ptr = 4'h0; m_data = 8'h00;
         end
         chk("ld_ready", ld_ready,
             m_mode == M_LOAD && m_age == 0);
         chk("cpu_hold", cpu_hold,
             m_mode == M_LOAD || m_mode == M_DONE);
         chk("prog_active", prog_active, m_mode != M_IDLE);
         chk("bus_oe", bus_oe,
             m_mode == M_LOAD && (m_age == 1 || m_age == 2));
         chk("nLma", nLma, !(m_mode == M_LOAD && m_age == 1));
         chk("nLmd", nLmd, !(m_mode == M_LOAD && m_age == 2));
         chk("nLr", nLr, !(m_mode == M_LOAD && m_age == 3));
         chk("pc_clr", pc_clr, m_mode == M_DONE && m_first);
         chk("byte_count", byte_count, m_cnt);
         chk("trunc", trunc, m_trunc);
         if (!nLma) chk("bus_addr", bus_out, m_ptr);
         if (!nLmd) chk("bus_data", bus_out, m_data);
         if (pc_clr) n_pc++;
         if (ld_valid && ld_ready && !rst) acc_q.push_back(cyc);
         if (!rst) begin
            case (m_mode)
               M_IDLE: if (prog_req) begin
                  m_mode = M_SYNC; m_cnt = 0;
                  m_trunc = 0; m_ptr = 4'h0;
               end
               M_SYNC: begin
                  if (!prog_req) m_mode = M_IDLE;
                  else if (cpu_at_t0) begin
                     m_mode = M_LOAD; m_age = 0;
                  end
               end
               M_LOAD: begin
                  if (m_age == 0) begin
                     if (ld_valid) begin
                        m_data = ld_data; m_last = ld_last;
                        m_age = 1;
                     end else if (!prog_req) begin
                        m_mode = M_DONE; m_first = 1;
                     end
                  end else if (m_age < 3) begin
                     m_age++;
                  end else begin
                     m_age = 0; m_ptr++; m_cnt++;
                     if (m_last || m_cnt == 16) begin
                        m_mode = M_DONE; m_first = 1;
                        if (!m_last) m_trunc = 1;
                     end
                  end
               end
               M_DONE: begin
                  m_first = 0;
                  if (!prog_req) m_mode = M_IDLE;
               end
               default: m_mode = M_IDLE;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      bit got = 0;
      ld_valid = 1'b1; ld_data = d; ld_last = l;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (ld_ready) got = 1;
      end
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("send_accept", got, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int na;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) tick();
      chk("rst_hold", cpu_hold, 0);
      chk("rst_nLr", nLr, 1);
      chk("rst_count", byte_count, 0);

      // basic load
      n_pc = 0; cpu_at_t0 = 1'b1; prog_req = 1'b1;
      send(8'h1A, 1'b0);
      send(8'h2B, 1'b0);
      send(8'h3C, 1'b1);
      repeat (6) tick();
      chk("basic_ram0", ram[0], 8'h1A);
      chk("basic_ram1", ram[1], 8'h2B);
      chk("basic_ram2", ram[2], 8'h3C);
      chk("basic_count", byte_count, 3);
      chk("basic_trunc", trunc, 0);
      chk("basic_pc_clr", n_pc, 1);
      prog_req = 1'b0;
      repeat (3) tick();
      chk("basic_idle", prog_active, 0);

      // full RAM, no last
      n_pc = 0; prog_req = 1'b1;
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      na = acc_q.size();
      ld_valid = 1'b1; ld_data = 8'hEE;
      repeat (12) tick();
      ld_valid = 1'b0;
      chk("full_no17th", acc_q.size(), na);
      chk("full_trunc", trunc, 1);
      chk("full_count", byte_count, 16);
      chk("full_hold", cpu_hold, 1);
      chk("full_pc_clr", n_pc, 1);
      for (int i = 0; i < 16; i++) chk("full_ram", ram[i], i);
      prog_req = 1'b0;
      repeat (3) tick();

      // sync wait
      cpu_at_t0 = 1'b0; prog_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("sync_hold", cpu_hold, 0);
         chk("sync_ready", ld_ready, 0);
      end
      tick();
      cpu_at_t0 = 1'b1;
      @(negedge clk);
      chk("sync_hold_pre", cpu_hold, 0);
      @(negedge clk);
      chk("sync_hold_rise", cpu_hold, 1);
      tick();

      // abort during DATA of byte 2
      n_pc = 0;
      send(8'hA1, 1'b0);
      send(8'hB2, 1'b0);
      tick();
      prog_req = 1'b0;
      repeat (8) tick();
      chk("abort_ram0", ram[0], 8'hA1);
      chk("abort_ram1", ram[1], 8'hB2);
      chk("abort_count", byte_count, 2);
      chk("abort_idle", prog_active, 0);
      chk("abort_pc_clr", n_pc, 1);

      // async reset in WRITE
      prog_req = 1'b1;
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      tick();
      tick();
      chk("pre_rst_nLr", nLr, 0);
      rst = 1'b1;
      #1;
      chk("arst_nLr", nLr, 1);
      chk("arst_oe", bus_oe, 0);
      chk("arst_hold", cpu_hold, 0);
      chk("arst_active", prog_active, 0);
      chk("arst_count", byte_count, 0);
      prog_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (2) tick();
      chk("arst_ram0", ram[0], 8'h55);
      chk("arst_ram1_lost", ram[1], 8'hB2);
      n_pc = 0; prog_req = 1'b1;
      send(8'h77, 1'b1);
      repeat (6) tick();
      chk("arst_restart_ram0", ram[0], 8'h77);
      chk("arst_restart_count", byte_count, 1);
      chk("arst_restart_pc", n_pc, 1);
      prog_req = 1'b0;
      repeat (3) tick();

      // back-pressure
      acc_q.delete();
      prog_req = 1'b1;
      ld_valid = 1'b1; ld_data = 8'hC0; ld_last = 1'b0;
      repeat (26) tick();
      ld_valid = 1'b0; prog_req = 1'b0;
      chk("bp_accepts", acc_q.size() >= 5, 1);
      for (int i = 1; i < acc_q.size(); i++)
         chk("bp_spacing", acc_q[i] - acc_q[i-1], 4);
      na = acc_q.size();
      repeat (8) tick();
      chk("bp_count", byte_count, na);
      chk("bp_idle", prog_active, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
